// File: rtl/datos_a_rgb_stream.sv
// rtl/datos_a_rgb_stream.sv - RGB565/RGB555 to OUT_W-per-channel RGB stream with frame/line tags.
// Optional luma output selected per pixel when DATOS_A_RGB_GRAY_EN is defined.
module datos_a_rgb_stream #(
    parameter int OUT_W = 8,
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fmt,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DATOS_A_RGB_GRAY_EN
    input  logic             gray_sel,
`endif
    output logic [OUT_W-1:0] R,
    output logic [OUT_W-1:0] G,
    output logic [OUT_W-1:0] B,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACT - 1);

    // Bit replication MSB-first, truncated to OUT_W (valid for OUT_W 5..12)
    function automatic logic [OUT_W-1:0] expand5(input logic [4:0] f);
        logic [14:0] rep;
        rep = {f, f, f};
        return rep[14 -: OUT_W];
    endfunction

    function automatic logic [OUT_W-1:0] expand6(input logic [5:0] f);
        logic [11:0] rep;
        rep = {f, f};
        return rep[11 -: OUT_W];
    endfunction

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             s1_valid_q, s1_valid_d;
    logic [4:0]       s1_r_q, s1_r_d;
    logic [5:0]       s1_g_q, s1_g_d;
    logic [4:0]       s1_b_q, s1_b_d;
    logic             s1_fmt_q, s1_fmt_d;
    logic             s1_sof_q, s1_sof_d;
    logic             s1_eol_q, s1_eol_d;
    logic             s1_gray_q, s1_gray_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;

    logic             out_free, s1_adv, in_fire, gray_in;
    logic [OUT_W-1:0] exp_r, exp_g, exp_b;

`ifdef DATOS_A_RGB_GRAY_EN
    localparam int LW = OUT_W + 8;
    logic [LW-1:0] luma_sum;
    assign gray_in  = gray_sel;
    assign luma_sum = {8'd0, exp_r} * LW'(77) + {8'd0, exp_g} * LW'(150)
                    + {8'd0, exp_b} * LW'(29);
`else
    assign gray_in = 1'b0;
`endif

    assign out_free = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && out_free;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        exp_r = expand5(s1_r_q);
        exp_b = expand5(s1_b_q);
        exp_g = s1_fmt_q ? expand5(s1_g_q[4:0]) : expand6(s1_g_q);
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        s1_fmt_d   = s1_fmt_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        s1_gray_d  = s1_gray_q;

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_fmt_d   = fmt;
            s1_gray_d  = gray_in;
            s1_b_d     = in_data[4:0];
            if (fmt) begin
                s1_r_d = in_data[14:10];
                s1_g_d = {1'b0, in_data[9:5]};
            end else begin
                s1_r_d = in_data[15:11];
                s1_g_d = in_data[10:5];
            end
            s1_sof_d = (col_q == '0) && (row_q == '0);
            s1_eol_d = (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        sof_d       = sof_q;
        eol_d       = eol_q;

        if (out_free) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            sof_d = s1_sof_q;
            eol_d = s1_eol_q;
`ifdef DATOS_A_RGB_GRAY_EN
            if (s1_gray_q) begin
                r_d = luma_sum[LW-1:8];
                g_d = luma_sum[LW-1:8];
                b_d = luma_sum[LW-1:8];
            end else begin
                r_d = exp_r;
                g_d = exp_g;
                b_d = exp_b;
            end
`else
            r_d = exp_r;
            g_d = exp_g;
            b_d = exp_b;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_g_q      <= '0;
            s1_b_q      <= '0;
            s1_fmt_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_gray_q   <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            s1_g_q      <= s1_g_d;
            s1_b_q      <= s1_b_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            s1_gray_q   <= s1_gray_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
        end
    end

    // Without luma support the per-pixel gray flag is always zero
    logic unused_gray;
    assign unused_gray = s1_gray_q;

    assign R         = r_q;
    assign G         = g_q;
    assign B         = b_q;
    assign out_sof   = sof_q;
    assign out_eol   = eol_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/datos_a_rgb_stream.md
DATOS_A_RGB_STREAM -- requirements
Module: datos_a_rgb_stream

Interface
REQ-001 Parameter OUT_W, default 8, SHALL set the output width per colour channel (legal 5..12).
REQ-002 Parameter H_ACT, default 640, SHALL set the number of pixels per line.
REQ-003 Parameter V_ACT, default 480, SHALL set the number of lines per frame.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes occur on the rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port fmt, input, 1 bit, SHALL select the input format: 0 = RGB565, 1 = RGB555 (bit 15 ignored).
REQ-007 Port in_data, input, 16 bits, SHALL carry the packed pixel.
REQ-008 Port in_valid, input, 1 bit, SHALL qualify in_data.
REQ-009 Port in_ready, output, 1 bit, SHALL indicate the block accepts a pixel this cycle.
REQ-010 Ports R, G, B, output, OUT_W bits each, SHALL carry the expanded pixel.
REQ-011 Ports out_sof and out_eol, output, 1 bit each, SHALL flag the first pixel of a frame and the last pixel of a line.
REQ-012 Port out_valid, output, 1 bit, SHALL qualify R, G, B, out_sof and out_eol.
REQ-013 Port out_ready, input, 1 bit, SHALL be the downstream acceptance.

Function
REQ-014 Transfers SHALL occur only when valid and ready are both high on a clock edge, on both input and output sides.
REQ-015 The block SHALL be a 2-stage pipeline: stage 1 registers the unpacked fields and stage 2 registers the expanded outputs; latency is 2 cycles from input transfer to out_valid with out_ready held high.
REQ-016 A stage SHALL load when it is empty or its content is being consumed in the same cycle; in_ready = !s1_valid | s1 advancing. Throughput SHALL be 1 pixel/cycle with out_ready high.
REQ-017 Field extraction for fmt=0 SHALL be R=[15:11], G=[10:5], B=[4:0]; for fmt=1 SHALL be R=[14:10], G=[9:5], B=[4:0].
REQ-018 Expansion of a field of width W to OUT_W SHALL repeat the field MSB-first and truncate to OUT_W bits (e.g. 5->8 gives {f,f[4:2]}, 6->8 gives {f,f[5:4]}).
REQ-019 fmt SHALL be sampled with each pixel at stage 1 and travel with it; a fmt change mid-stream affects only later pixels.
REQ-020 A column counter (0..H_ACT-1) and a row counter (0..V_ACT-1) SHALL advance on each input transfer; the column wraps to 0 and increments the row at H_ACT-1; the row wraps to 0 after V_ACT-1.
REQ-021 sof SHALL be tagged where column=0 and row=0, and eol where column=H_ACT-1; the tags SHALL travel with the pixel through both stages.
REQ-022 While out_valid=1 and out_ready=0, all outputs SHALL hold stable and no data SHALL be lost or duplicated.
REQ-023 With both stages full and out_ready=0, in_ready SHALL be 0.

Reset
REQ-024 On rst_n low, both stage valid bits, out_valid, out_sof, out_eol, R, G, B and both counters SHALL clear to 0 asynchronously.
REQ-025 in_ready SHALL be 1 in the first cycle after reset release.
REQ-026 Reset mid-frame SHALL discard in-flight pixels; the next accepted pixel SHALL be tagged sof.

Configuration
REQ-027 With macro DATOS_A_RGB_GRAY_EN defined, an input gray_sel (1 bit, sampled with the pixel) SHALL be added; when gray_sel=1, R=G=B=(77*R+150*G+29*B)>>8, computed on the expanded values, with latency unchanged.
REQ-028 Without DATOS_A_RGB_GRAY_EN, the gray_sel port and the luma logic SHALL be absent.

Verification
REQ-029 fmt=0, in_data=0xF800, out_ready=1 -> 2 cycles later R=0xFF, G=0x00, B=0x00, out_valid=1.
REQ-030 fmt=0, in_data=0x8410 -> R=0x84, G=0x82, B=0x84; fmt=1, in_data=0x7C00 -> R=0xFF, G=0x00, B=0x00.
REQ-031 Stream of 4 pixels with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 accepted pixels, and all 4 pixels emerge in order, unchanged.
REQ-032 H_ACT=4, V_ACT=2, 8 pixels -> out_sof on pixel 0 only; out_eol on pixels 3 and 7; pixel 8 is tagged sof.
REQ-033 rst_n pulsed low after 5 pixels -> outputs 0 immediately; the next pixel is tagged sof.
REQ-034 DATOS_A_RGB_GRAY_EN defined, gray_sel=1, in_data=0xFFFF -> R=G=B=0xFF; in_data=0xF800 -> R=G=B=0x4C.
